// File: rtl/load_store_unit_if.sv
// Core request/response channel and word-memory port of the load/store unit.
// slave: the LSU side; master: the core plus memory environment.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_write_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_write_en, mem_addr, mem_write_data
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_write_en, mem_addr, mem_write_data
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed data memory.
// Optional macro LSU_ALIGN_CHECK_EN turns misaligned half/word accesses into errors.
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.slave   bus
);

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned HALF_W     = 16;
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(MEM_WORDS) << 2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Latched request fields
    logic              we_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [1:0]        lane_q;
    logic [HALF_W-1:0] wdata_q;

    // Registered outputs and their next values
    logic              req_ready_q,      req_ready_d;
    logic              resp_valid_q,     resp_valid_d;
    logic              resp_err_q,       resp_err_d;
    logic [DATA_W-1:0] resp_rdata_q,     resp_rdata_d;
    logic              mem_write_en_q,   mem_write_en_d;
    logic [ADDR_W-1:0] mem_addr_q,       mem_addr_d;
    logic [DATA_W-1:0] mem_write_data_q, mem_write_data_d;

    logic              accept_c;
    logic              req_bad_c;
    logic [1:0]        req_lane_c;
    logic [DATA_W-1:0] load_value_c;
    logic [DATA_W-1:0] merge_value_c;

    // Request decode: acceptance, error classification and lane after alignment forcing
    always_comb begin
        accept_c  = bus.req_valid && (state_q == IDLE);
        req_bad_c = (bus.req_size == SZ_RSVD) || ({1'b0, bus.req_addr} >= ADDR_LIMIT);
`ifdef LSU_ALIGN_CHECK_EN
        if ((bus.req_size == SZ_HALF && bus.req_addr[0]) ||
            (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00)) begin
            req_bad_c = 1'b1;
        end
`endif
        case (bus.req_size)
            SZ_HALF: req_lane_c = {bus.req_addr[1], 1'b0};
            SZ_WORD: req_lane_c = 2'b00;
            default: req_lane_c = bus.req_addr[1:0];
        endcase
    end

    // Lane select and extension of the memory word for loads
    always_comb begin
        logic [7:0]        byte_sel;
        logic [HALF_W-1:0] half_sel;
        byte_sel     = 8'(bus.mem_read_data >> {lane_q, 3'b000});
        half_sel     = lane_q[1] ? bus.mem_read_data[31:16] : bus.mem_read_data[15:0];
        load_value_c = '0;
        case (size_q)
            SZ_BYTE: load_value_c = signed_q ? {{24{byte_sel[7]}}, byte_sel}
                                             : {24'h0, byte_sel};
            SZ_HALF: load_value_c = signed_q ? {{16{half_sel[15]}}, half_sel}
                                             : {16'h0, half_sel};
            SZ_WORD: load_value_c = bus.mem_read_data;
            default: load_value_c = '0;
        endcase
    end

    // Read-modify-write merge: replace the target lane(s) of the current memory word
    always_comb begin
        logic [4:0] shift;
        shift         = {lane_q, 3'b000};
        merge_value_c = bus.mem_read_data;
        if (size_q == SZ_BYTE) begin
            merge_value_c = (bus.mem_read_data & ~(32'h0000_00FF << shift)) |
                            (DATA_W'(wdata_q[7:0]) << shift);
        end else if (lane_q[1]) begin
            merge_value_c = {wdata_q, bus.mem_read_data[15:0]};
        end else begin
            merge_value_c = {bus.mem_read_data[31:16], wdata_q};
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept_c) state_d = req_bad_c ? RESP : ACCESS;
            end
            ACCESS: begin
                state_d = (we_q && size_q != SZ_WORD) ? WRITE : RESP;
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, aligned with state_d
    always_comb begin
        req_ready_d      = (state_d == IDLE);
        resp_valid_d     = (state_d == RESP);
        resp_err_d       = 1'b0;
        resp_rdata_d     = '0;
        mem_write_en_d   = 1'b0;
        mem_addr_d       = mem_addr_q;
        mem_write_data_d = mem_write_data_q;
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (req_bad_c) begin
                        resp_err_d = 1'b1;
                    end else begin
                        mem_addr_d = {2'b00, bus.req_addr[ADDR_W-1:2]};
                        if (bus.req_we && bus.req_size == SZ_WORD) begin
                            mem_write_en_d   = 1'b1;
                            mem_write_data_d = bus.req_wdata;
                        end
                    end
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    resp_rdata_d = load_value_c;
                end else if (size_q != SZ_WORD) begin
                    mem_write_en_d   = 1'b1;
                    mem_write_data_d = merge_value_c;
                end
            end
            default: ;
        endcase
    end

    // Output registers and request latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_ready_q      <= 1'b1;
            resp_valid_q     <= 1'b0;
            resp_err_q       <= 1'b0;
            resp_rdata_q     <= '0;
            mem_write_en_q   <= 1'b0;
            mem_addr_q       <= '0;
            mem_write_data_q <= '0;
            we_q             <= 1'b0;
            size_q           <= SZ_BYTE;
            signed_q         <= 1'b0;
            lane_q           <= 2'b00;
            wdata_q          <= '0;
        end else begin
            req_ready_q      <= req_ready_d;
            resp_valid_q     <= resp_valid_d;
            resp_err_q       <= resp_err_d;
            resp_rdata_q     <= resp_rdata_d;
            mem_write_en_q   <= mem_write_en_d;
            mem_addr_q       <= mem_addr_d;
            mem_write_data_q <= mem_write_data_d;
            if (accept_c) begin
                we_q     <= bus.req_we;
                size_q   <= bus.req_size;
                signed_q <= bus.req_signed;
                lane_q   <= req_lane_c;
                wdata_q  <= bus.req_wdata[HALF_W-1:0];
            end
        end
    end

    assign bus.req_ready      = req_ready_q;
    assign bus.resp_valid     = resp_valid_q;
    assign bus.resp_err       = resp_err_q;
    assign bus.resp_rdata     = resp_rdata_q;
    assign bus.mem_write_en   = mem_write_en_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus random traffic
// checked against a byte-array reference model.
module tb_load_store_unit;

    localparam int unsigned MEM_WORDS = 1024;
    localparam int unsigned MEM_BYTES = MEM_WORDS * 4;

    logic clk = 1'b0;
    logic rst;
    logic mem_clear;

    int tests_run    = 0;
    int tests_failed = 0;
    int wen_count    = 0;

    logic [31:0] dmem    [MEM_WORDS];
    logic [7:0]  ref_mem [MEM_BYTES];

    load_store_unit_if bus ();

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Word memory seen by the DUT: combinational read, posedge write
    assign bus.mem_read_data = dmem[bus.mem_addr % MEM_WORDS];

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < int'(MEM_WORDS); i++) dmem[i] <= 32'h0;
        end else if (bus.mem_write_en) begin
            dmem[bus.mem_addr % MEM_WORDS] <= bus.mem_write_data;
        end
    end

    always @(posedge clk) begin
        if (bus.mem_write_en) wen_count <= wen_count + 1;
    end

    // Reference model: little-endian byte memory, updated on successful stores
    function automatic void model(input logic we, input logic [1:0] size, input logic sgn,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic [31:0] rd, output logic err,
                                  output int lat, output int wen);
        int n;
        logic [31:0] a;
        logic [31:0] v;
        n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        err = (size == 2'd3) || (addr >= 32'(MEM_BYTES));
`ifdef LSU_ALIGN_CHECK_EN
        if (addr % n != 0) err = 1'b1;
`endif
        rd  = 32'h0;
        lat = 1;
        wen = 0;
        if (err) return;
        a = addr - (addr % n);
        if (we) begin
            for (int i = 0; i < n; i++) ref_mem[a + i] = wdata[8*i +: 8];
            lat = (n == 4) ? 2 : 3;
            wen = 1;
        end else begin
            v = 32'h0;
            for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + i]) << (8*i));
            if (sgn && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
            rd  = v;
            lat = 2;
        end
    endfunction

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_mem[4*idx+3], ref_mem[4*idx+2], ref_mem[4*idx+1], ref_mem[4*idx]};
    endfunction

    // One full transaction: handshake, latency, response, write-pulse count
    task automatic do_req(input string name, input logic we, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat, exp_wen, lat, guard, wen_before;
        logic        got;
        rdata = 32'h0;
        err   = 1'b0;
        model(we, size, sgn, addr, wdata, exp_rd, exp_err, exp_lat, exp_wen);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        guard = 0;
        while (!bus.req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        tests_run++;
        if (!bus.req_ready) begin
            tests_failed++;
            $display("FAIL %s ready_timeout: req_ready=%b required 1", name, bus.req_ready);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        wen_before     = wen_count;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'($urandom);
        bus.req_size   = 2'($urandom);
        bus.req_signed = 1'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 10) begin
            @(negedge clk);
            lat++;
            if (bus.resp_valid) got = 1'b1;
        end
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        tests_run++;
        if (!got || lat != exp_lat) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d (seen=%b) required %0d", name, lat, got, exp_lat);
        end
        tests_run++;
        if (err !== exp_err) begin
            tests_failed++;
            $display("FAIL %s resp_err: got %b required %b", name, err, exp_err);
        end
        tests_run++;
        if (rdata !== exp_rd) begin
            tests_failed++;
            $display("FAIL %s resp_rdata: got %h required %h", name, rdata, exp_rd);
        end
        tests_run++;
        if (wen_count - wen_before != exp_wen) begin
            tests_failed++;
            $display("FAIL %s write_pulses: got %0d required %0d", name, wen_count - wen_before, exp_wen);
        end
        @(negedge clk);
        tests_run++;
        if (bus.resp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s resp_pulse_width: resp_valid=%b required 0", name, bus.resp_valid);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b0;
        mem_clear = 1'b1;
        for (int i = 0; i < int'(MEM_BYTES); i++) ref_mem[i] = 8'h0;
        repeat (3) @(negedge clk);
        tests_run += 7;
        if (bus.req_ready !== 1'b1)        begin tests_failed++; $display("FAIL reset req_ready: got %b required 1", bus.req_ready); end
        if (bus.resp_valid !== 1'b0)       begin tests_failed++; $display("FAIL reset resp_valid: got %b required 0", bus.resp_valid); end
        if (bus.resp_rdata !== 32'h0)      begin tests_failed++; $display("FAIL reset resp_rdata: got %h required 0", bus.resp_rdata); end
        if (bus.resp_err !== 1'b0)         begin tests_failed++; $display("FAIL reset resp_err: got %b required 0", bus.resp_err); end
        if (bus.mem_write_en !== 1'b0)     begin tests_failed++; $display("FAIL reset mem_write_en: got %b required 0", bus.mem_write_en); end
        if (bus.mem_addr !== 32'h0)        begin tests_failed++; $display("FAIL reset mem_addr: got %h required 0", bus.mem_addr); end
        if (bus.mem_write_data !== 32'h0)  begin tests_failed++; $display("FAIL reset mem_write_data: got %h required 0", bus.mem_write_data); end
        rst       = 1'b1;
        mem_clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word();
        logic [31:0] rd;
        logic        e;
        do_req("word_store", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, e);
        do_req("word_load",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, e);
        tests_run++;
        if (rd !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL word_load_const: got %h required DEADBEEF", rd);
        end
    endtask

    task automatic test_byte();
        logic [31:0] rd;
        logic        e;
        do_req("byte_prep",  1'b1, 2'b10, 1'b0, 32'h0, 32'h0000_000A, rd, e);
        do_req("byte_store", 1'b1, 2'b00, 1'b0, 32'h1, 32'h0000_00FF, rd, e);
        tests_run++;
        if (dmem[0] !== 32'h0000_FF0A) begin
            tests_failed++;
            $display("FAIL byte_merge: mem[0]=%h required 0000FF0A", dmem[0]);
        end
        do_req("byte_load_s", 1'b0, 2'b00, 1'b1, 32'h1, 32'h0, rd, e);
        tests_run++;
        if (rd !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL byte_sext: got %h required FFFFFFFF", rd); end
        do_req("byte_load_u", 1'b0, 2'b00, 1'b0, 32'h1, 32'h0, rd, e);
        tests_run++;
        if (rd !== 32'h0000_00FF) begin tests_failed++; $display("FAIL byte_zext: got %h required 000000FF", rd); end
    endtask

    task automatic test_half();
        logic [31:0] rd, w;
        logic        e;
        w = $urandom;
        do_req("half_prep",  1'b1, 2'b10, 1'b0, 32'h4, w, rd, e);
        do_req("half_store", 1'b1, 2'b01, 1'b0, 32'h6, 32'h1234_8001, rd, e);
        do_req("half_load",  1'b0, 2'b01, 1'b1, 32'h6, 32'h0, rd, e);
        tests_run++;
        if (rd !== 32'hFFFF_8001) begin tests_failed++; $display("FAIL half_sext: got %h required FFFF8001", rd); end
        tests_run++;
        if (dmem[1] !== {16'h8001, w[15:0]}) begin
            tests_failed++;
            $display("FAIL half_merge: mem[1]=%h required %h", dmem[1], {16'h8001, w[15:0]});
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        e;
        do_req("err_range",    1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0, rd, e);
        do_req("err_rsvd",     1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0, rd, e);
        do_req("err_store_hi", 1'b1, 2'b00, 1'b0, 32'hFFFF_FFFC, 32'h55, rd, e);
        do_req("err_store_sz", 1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'h1, rd, e);
        tests_run++;
        if (dmem[4] !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL err_no_write: mem[4]=%h required DEADBEEF", dmem[4]);
        end
    endtask

    task automatic test_align();
        logic [31:0] rd;
        logic        e;
        logic [31:0] exp_w0;
`ifdef LSU_ALIGN_CHECK_EN
        exp_w0 = 32'h0000_FF0A;
`else
        exp_w0 = 32'hBEEF_FF0A;
`endif
        do_req("misaligned_half", 1'b1, 2'b01, 1'b0, 32'h3, 32'h0000_BEEF, rd, e);
        tests_run++;
        if (dmem[0] !== exp_w0) begin
            tests_failed++;
            $display("FAIL misaligned_mem: mem[0]=%h required %h", dmem[0], exp_w0);
        end
        do_req("misaligned_word", 1'b0, 2'b10, 1'b0, 32'h2, 32'h0, rd, e);
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        e;
        do_req("abort_prep", 1'b1, 2'b10, 1'b0, 32'h8, 32'h1122_3344, rd, e);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h9;
        bus.req_wdata  = 32'h0000_00AA;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (bus.mem_write_en !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_in_write: mem_write_en=%b required 1", bus.mem_write_en);
        end
        rst = 1'b0;
        #1;
        tests_run++;
        if (bus.mem_write_en !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_wen_drop: mem_write_en=%b required 0", bus.mem_write_en);
        end
        @(posedge clk);
        @(negedge clk);
        tests_run += 2;
        if (bus.resp_valid !== 1'b0) begin tests_failed++; $display("FAIL abort_no_resp: resp_valid=%b required 0", bus.resp_valid); end
        if (dmem[2] !== 32'h1122_3344) begin tests_failed++; $display("FAIL abort_mem: mem[2]=%h required 11223344", dmem[2]); end
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (bus.req_ready !== 1'b1) begin tests_failed++; $display("FAIL abort_ready: req_ready=%b required 1", bus.req_ready); end
        do_req("abort_after", 1'b0, 2'b10, 1'b0, 32'h8, 32'h0, rd, e);
    endtask

    task automatic test_random();
        logic [31:0] rd, addr;
        logic [1:0]  size;
        logic        e;
        int          r;
        for (int i = 0; i < 200; i++) begin
            r    = int'($urandom_range(0, 15));
            size = (r == 0) ? 2'b11 : 2'(r % 3);
            addr = (r == 1) ? 32'h0000_1000 + $urandom_range(0, 255) : 32'($urandom_range(0, 63));
            do_req("random", 1'($urandom), size, 1'($urandom), addr, $urandom, rd, e);
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_align();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
